vending_ctrl_param: RTL and testbench

//  Parametrised single-product vending controller. Accumulates coin credit in

---
 rtl/vending_ctrl_param_if.sv | 29 ++
 rtl/vending_ctrl_param.sv | 125 ++++++++++++
 tb/tb_vending_ctrl_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/vending_ctrl_param_if.sv
// Coin-in / vend-and-change-out bundle between the coin front end, the
// controller and the dispenser/hopper side.
interface vending_ctrl_param_if #(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned SALES_W  = 8
);
  logic                nickel_i;
  logic                dime_i;
  logic                quarter_i;
  logic                cancel_i;
  logic                soda_o;
  logic [CREDIT_W-1:0] change_o;
  logic                change_vld_o;
  logic                reject_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                busy_o;
  logic [SALES_W-1:0]  sales_o;

  // Master drives coins/cancel and observes vend results.
  modport master (
    output nickel_i, dime_i, quarter_i, cancel_i,
    input  soda_o, change_o, change_vld_o, reject_o, credit_o, busy_o, sales_o
  );

  modport slave (
    input  nickel_i, dime_i, quarter_i, cancel_i,
    output soda_o, change_o, change_vld_o, reject_o, credit_o, busy_o, sales_o
  );
endinterface

// File: rtl/vending_ctrl_param.sv
// Single-product vending controller: accumulates coin credit, vends at PRICE,
// returns change, supports cancel/refund, coin rejection and a sales counter.
module vending_ctrl_param #(
  parameter int unsigned PRICE       = 4,
  parameter int unsigned NICKEL_VAL  = 1,
  parameter int unsigned DIME_VAL    = 2,
  parameter int unsigned QUARTER_VAL = 5,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned SALES_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vending_ctrl_param_if.slave bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_REFUND
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [SALES_W-1:0]  sales_q, sales_d;
  logic                soda_q, soda_d;
  logic                vld_q, vld_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                any_coin;
  logic                multi_coin;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;

  // Coin decode: highest value wins when several detectors fire together.
  always_comb begin
    any_coin   = bus.nickel_i | bus.dime_i | bus.quarter_i;
    multi_coin = (bus.nickel_i & bus.dime_i) | (bus.nickel_i & bus.quarter_i) |
                 (bus.dime_i & bus.quarter_i);
    coin_val   = '0;
    if (bus.quarter_i)     coin_val = SUM_W'(QUARTER_VAL);
    else if (bus.dime_i)   coin_val = SUM_W'(DIME_VAL);
    else if (bus.nickel_i) coin_val = SUM_W'(NICKEL_VAL);
    sum = {1'b0, credit_q} + coin_val;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = ST_IDLE;
    credit_d = credit_q;
    change_d = '0;
    sales_d  = sales_q;
    soda_d   = 1'b0;
    vld_d    = 1'b0;
    reject_d = 1'b0;

    case (state_q)
      ST_DISPENSE, ST_REFUND: begin
        credit_d = '0;
        reject_d = any_coin;
      end
      default: begin
        if (bus.cancel_i && (credit_q != '0)) begin
          state_d  = ST_REFUND;
          vld_d    = 1'b1;
          change_d = credit_q;
          credit_d = '0;
          reject_d = any_coin;
        end else if (any_coin) begin
          reject_d = multi_coin;
          if (sum >= SUM_W'(PRICE)) begin
            state_d  = ST_DISPENSE;
            soda_d   = 1'b1;
            vld_d    = 1'b1;
            change_d = CREDIT_W'(sum - SUM_W'(PRICE));
            credit_d = '0;
            sales_d  = sales_q + SALES_W'(1);
          end else begin
            state_d  = ST_COLLECT;
            credit_d = CREDIT_W'(sum);
          end
        end else begin
          state_d = (credit_q == '0) ? ST_IDLE : ST_COLLECT;
        end
      end
    endcase

    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_REFUND);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      sales_q  <= '0;
      soda_q   <= 1'b0;
      vld_q    <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      sales_q  <= sales_d;
      soda_q   <= soda_d;
      vld_q    <= vld_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.soda_o       = soda_q;
  assign bus.change_o     = change_q;
  assign bus.change_vld_o = vld_q;
  assign bus.reject_o     = reject_q;
  assign bus.credit_o     = credit_q;
  assign bus.busy_o       = busy_q;
  assign bus.sales_o      = sales_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: directed scenarios plus random coin traffic
// compared every cycle against a credit/sales arithmetic model.
module tb_vending_ctrl_param;
  localparam int PRICE = 4;
  localparam int CW    = 4;
  localparam int SW    = 8;

  logic clk = 1'b0;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: credit in units, sales count, and whether a vend/refund
  // cycle is in progress.
  int m_credit;
  int m_sales;
  bit m_busy;

  vending_ctrl_param_if #(.CREDIT_W(CW), .SALES_W(SW)) vif ();

  vending_ctrl_param #(
    .PRICE(PRICE), .NICKEL_VAL(1), .DIME_VAL(2), .QUARTER_VAL(5),
    .CREDIT_W(CW), .SALES_W(SW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_sales  = 0;
    m_busy   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, compare every output.
  task automatic apply(input bit n, input bit d, input bit q, input bit c);
    int cnt, val, s, e_chg;
    bit e_soda, e_vld, e_rej;
    @(negedge clk);
    vif.nickel_i  = n;
    vif.dime_i    = d;
    vif.quarter_i = q;
    vif.cancel_i  = c;
    @(posedge clk);
    #1;
    cnt    = int'(n) + int'(d) + int'(q);
    val    = q ? 5 : (d ? 2 : (n ? 1 : 0));
    e_soda = 1'b0; e_vld = 1'b0; e_rej = 1'b0; e_chg = 0;
    if (m_busy) begin
      e_rej    = (cnt > 0);
      m_credit = 0;
      m_busy   = 1'b0;
    end else if (c && m_credit > 0) begin
      e_vld    = 1'b1;
      e_chg    = m_credit;
      e_rej    = (cnt > 0);
      m_credit = 0;
      m_busy   = 1'b1;
    end else if (cnt > 0) begin
      e_rej = (cnt > 1);
      s     = m_credit + val;
      if (s >= PRICE) begin
        e_soda   = 1'b1;
        e_vld    = 1'b1;
        e_chg    = s - PRICE;
        m_sales  = (m_sales + 1) % (1 << SW);
        m_credit = 0;
        m_busy   = 1'b1;
      end else begin
        m_credit = s;
      end
    end
    check("soda",   32'(vif.soda_o),       32'(e_soda));
    check("vld",    32'(vif.change_vld_o), 32'(e_vld));
    if (e_vld) check("change", 32'(vif.change_o), 32'(e_chg));
    check("reject", 32'(vif.reject_o),     32'(e_rej));
    check("credit", 32'(vif.credit_o),     32'(m_credit));
    check("busy",   32'(vif.busy_o),       32'(m_busy));
    check("sales",  32'(vif.sales_o),      32'(m_sales));
  endtask

  initial begin
    rst_n = 1'b0;
    vif.nickel_i = 1'b0; vif.dime_i = 1'b0; vif.quarter_i = 1'b0; vif.cancel_i = 1'b0;
    model_reset();
    #12;
    check("rst_soda",   32'(vif.soda_o),       0);
    check("rst_vld",    32'(vif.change_vld_o), 0);
    check("rst_reject", 32'(vif.reject_o),     0);
    check("rst_credit", 32'(vif.credit_o),     0);
    check("rst_busy",   32'(vif.busy_o),       0);
    check("rst_sales",  32'(vif.sales_o),      0);
    @(negedge clk); rst_n = 1'b1;

    // Four nickels: credit 1,2,3 then vend with zero change.
    apply(1, 0, 0, 0); check("nnnn_c1", 32'(vif.credit_o), 1);
    apply(1, 0, 0, 0); check("nnnn_c2", 32'(vif.credit_o), 2);
    apply(1, 0, 0, 0); check("nnnn_c3", 32'(vif.credit_o), 3);
    apply(1, 0, 0, 0);
    check("nnnn_soda",  32'(vif.soda_o),   1);
    check("nnnn_chg",   32'(vif.change_o), 0);
    check("nnnn_sales", 32'(vif.sales_o),  1);
    apply(0, 0, 0, 0);

    // Dime then quarter: 15c change.
    apply(0, 1, 0, 0); check("dq_c2", 32'(vif.credit_o), 2);
    apply(0, 0, 1, 0);
    check("dq_soda",   32'(vif.soda_o),       1);
    check("dq_vld",    32'(vif.change_vld_o), 1);
    check("dq_chg",    32'(vif.change_o),     3);
    check("dq_credit", 32'(vif.credit_o),     0);
    apply(0, 0, 0, 0);

    // Nickel, dime, cancel: refund 3 units, no vend.
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    check("cxl_vld",  32'(vif.change_vld_o), 1);
    check("cxl_chg",  32'(vif.change_o),     3);
    check("cxl_soda", 32'(vif.soda_o),       0);
    apply(0, 0, 0, 0);
    check("cxl_idle", 32'(vif.busy_o), 0);

    // Dime+quarter together, then a nickel while dispensing.
    apply(0, 1, 1, 0);
    check("dq2_rej",  32'(vif.reject_o), 1);
    check("dq2_soda", 32'(vif.soda_o),   1);
    check("dq2_chg",  32'(vif.change_o), 1);
    apply(1, 0, 0, 0);
    check("busy_rej",    32'(vif.reject_o), 1);
    check("busy_credit", 32'(vif.credit_o), 0);
    apply(0, 0, 0, 0);

    // Sales counter wrap.
    while (m_sales != 255) begin
      apply(0, 0, 1, 0);
      apply(0, 0, 0, 0);
    end
    check("sales_255", 32'(vif.sales_o), 255);
    apply(0, 0, 1, 0);
    check("sales_wrap", 32'(vif.sales_o), 0);
    apply(0, 0, 0, 0);

    // Asynchronous reset in the middle of a vend cycle.
    apply(0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_soda",   32'(vif.soda_o),   0);
    check("arst_credit", 32'(vif.credit_o), 0);
    check("arst_busy",   32'(vif.busy_o),   0);
    model_reset();
    vif.quarter_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Random coin traffic.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
